// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the 8-bit switch debouncer: FSM states, default
// debounce length and a counter-width helper.
package sw_debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and commit of the
// accepted level. While run_i is low the stable level tracks the synchronizer.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int          CNT_W           = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  input  logic run_i,
  output logic stable_nxt_o,
  output logic commit_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any return to the stable level before the last count clears the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    commit_o = 1'b0;
    if (!run_i) begin
      stable_d = s2_q;
    end else if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
        commit_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_nxt_o = stable_d;

endmodule

// File: rtl/sw_debounce8.sv
// Eight-switch debouncer: settle period after reset, then per-bit debounce
// with a registered change pulse and nonzero flag aligned to o_data.
//   state  | meaning
//   SETTLE | stable levels track the synchronizers, outputs held at zero
//   RUN    | per-bit debounce active, o_ready high until the next reset
module sw_debounce8
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_sw,
  output logic [7:0] o_data,
  output logic       o_ready,
  output logic       o_change,
  output logic       o_nonzero
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int SET_W = cnt_width(DEBOUNCE_CYCLES + 2);
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(DEBOUNCE_CYCLES + 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]       o_data_q, o_data_d;
  logic             o_change_q, o_change_d;
  logic             o_nonzero_q, o_nonzero_d;
  logic [7:0]       stable_nxt;
  logic [7:0]       commit;
  logic             run;

  assign run = (state_q == RUN);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_i        (i_sw[i]),
      .run_i       (run),
      .stable_nxt_o(stable_nxt[i]),
      .commit_o    (commit[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      o_data_q     <= '0;
      o_change_q   <= 1'b0;
      o_nonzero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      o_data_q     <= o_data_d;
      o_change_q   <= o_change_d;
      o_nonzero_q  <= o_nonzero_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + SET_W'(1);
        if (settle_cnt_d == SETTLE_DONE) state_d = RUN;
      end
      RUN: state_d = RUN;
    endcase
  end

  // Outputs are loaded from next-state values so they land on the commit edge.
  always_comb begin
    o_data_d    = (state_d == RUN) ? stable_nxt : 8'h00;
    o_nonzero_d = |o_data_d;
    o_change_d  = |commit;
  end

  assign o_data    = o_data_q;
  assign o_ready   = run;
  assign o_change  = o_change_q;
  assign o_nonzero = o_nonzero_q;

endmodule

// File: doc/sw_debounce8.md
SW_DEBOUNCE8 -- requirements
Module: sw_debounce8

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, which sets the number of consecutive stable synchronized cycles required to accept a bit change (synthesis builds override it to 1_000_000).
REQ-002 SHALL have localparam CNT_W = $clog2(DEBOUNCE_CYCLES), minimum 1, which sets the counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge clocked.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_sw, input, 8 bits: raw switch/button levels, asynchronous to clk and possibly bouncing.
REQ-006 SHALL have port o_data, output, 8 bits: the debounced switch vector, which feeds the downstream priority encoder data input.
REQ-007 SHALL have port o_ready, output, 1 bit: high once the settle period is complete, and drives the downstream encoder enable.
REQ-008 SHALL have port o_change, output, 1 bit: a one-cycle pulse whenever any o_data bit changes.
REQ-009 SHALL have port o_nonzero, output, 1 bit: registered reduction-OR of o_data.

Function
REQ-010 SHALL synchronize each i_sw bit through two flops (s1, s2) before any other use.
REQ-011 SHALL implement the top-level FSM with states SETTLE and RUN; reset enters SETTLE.
REQ-012 In SETTLE, SHALL load the stable register from s2 every cycle, hold o_data=0, o_change=0, o_nonzero=0 and o_ready=0, and count cycles with a settle counter.
REQ-013 SHALL transition SETTLE->RUN on the edge where the settle counter reaches DEBOUNCE_CYCLES+1; o_ready goes to 1 and o_data shows the stable register from that edge onward.
REQ-014 SHALL never leave RUN except on reset, with o_ready held at 1 throughout RUN.
REQ-015 In RUN, SHALL give each bit an independent counter: increment when s2 differs from the stable bit, clear to 0 when they are equal.
REQ-016 SHALL, on the edge where a bit counter equals DEBOUNCE_CYCLES-1 and s2 still differs, load the stable bit from s2 and clear that counter.
REQ-017 SHALL have a latency of exactly DEBOUNCE_CYCLES+2 rising edges from the first edge sampling a steady new i_sw level to the updated o_data (first sampling edge counted as 1).
REQ-018 SHALL reject as a glitch any s2 deviation lasting fewer than DEBOUNCE_CYCLES cycles: o_data is unchanged and the counter returns to 0.
REQ-019 SHALL register o_change so it is high during exactly the cycle in which o_data first shows a new value, and low otherwise.
REQ-020 SHALL produce a single o_change pulse when several bits commit on the same edge.
REQ-021 SHALL commit bits on different edges independently, each commit producing its own o_change pulse; back-to-back commits yield consecutive pulses.
REQ-022 SHALL update o_nonzero on the same edge as o_data, giving it zero extra latency relative to o_data.
REQ-023 SHALL saturate nothing: counters are guaranteed not to exceed DEBOUNCE_CYCLES-1 by REQ-016.

Reset
REQ-024 SHALL, with rst_n low, asynchronously clear s1, s2, the stable register, all counters, o_data, o_change, o_nonzero and o_ready, and force state SETTLE.
REQ-025 SHALL treat reset asserted mid-debounce (any state, any counter value) identically to power-on reset, discarding any partial count.
REQ-026 SHALL make reset deassertion take effect on the next rising clk edge; SETTLE then restarts from count 0.

Structure
REQ-027 SHALL place the shared package sw_debounce_pkg contents as follows: state enum {SETTLE, RUN} and the default DEBOUNCE_CYCLES constant.
REQ-028 SHALL implement the per-bit synchronizer, counter and commit logic in sub-module debounce_bit, instantiated 8 times; the FSM, o_change and o_nonzero logic reside in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset release scenario: release reset with i_sw=8'hA5 held -> o_ready=0 and o_data=0 for 5 edges, then o_ready=1 and o_data=8'hA5, with no o_change pulse.
REQ-030 Clean step scenario: in RUN, step i_sw 8'h00->8'h10 -> o_data=8'h10 exactly 6 edges after the first sampling edge, o_change high for one cycle, o_nonzero=1.
REQ-031 Glitch scenario: pulse i_sw[3] high for 3 cycles, then low -> o_data unchanged and o_change never asserted.
REQ-032 Bounce scenario: toggle i_sw[7] for 10 cycles, then hold 1 -> a single commit 6 edges after the final steady sample, with one o_change pulse.
REQ-033 Staggered bits scenario: raise bit0, then bit1 one cycle later -> two o_data updates on consecutive edges with two consecutive o_change pulses; raise both bits simultaneously -> one pulse.
REQ-034 Mid-operation reset scenario: assert rst_n low while a counter is at 2 -> all outputs 0 immediately; after release, the SETTLE sequence repeats as in REQ-029.
